// File: rtl/somador_serial_hex_if.sv
// rtl/somador_serial_hex_if.sv - start/busy/done handshake and operand/result bundle
interface somador_serial_hex_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, sub, cin, a, b, input busy, done, sum, cout);
  modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/somador_serial_hex.sv
// rtl/somador_serial_hex.sv - bit-serial add/sub, one full-adder cell, hex display of result
module somador_serial_hex #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  somador_serial_hex_if.slave  bus,
  output logic [7*NDIG-1:0]    hex
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = 4 * NDIG;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             carry;
  logic             s;
  logic             maj;
  logic             last;

  assign s    = ra[0] ^ rb[0] ^ carry;
  assign maj  = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      count    <= '0;
      carry    <= 1'b0;
      ra       <= '0;
      rb       <= '0;
      res      <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry flop.
            ra       <= bus.a;
            rb       <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? 1'b1 : bus.cin;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          res   <= {s, res[WIDTH-1:1]};
          carry <= maj;
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          count <= count + 1'b1;
          if (last) begin
            // Final bit goes straight into the output register so sum never shows partials.
            bus.sum  <= {s, res[WIDTH-1:1]};
            bus.cout <= maj;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0] padded;

  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = bus.sum;
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    assign hex[7*k +: 7] = seg7(padded[4*k +: 4]);
  end
endmodule

// File: tb/tb_somador_serial_hex.sv
// tb/tb_somador_serial_hex.sv - randomized checks of the serial adder against an arithmetic model
module tb_somador_serial_hex;
  logic CLOCK_50 = 1'b0;
  logic reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  somador_serial_hex_if #(.WIDTH(8))  bus8 ();
  somador_serial_hex_if #(.WIDTH(32)) bus32 ();
  somador_serial_hex_if #(.WIDTH(4))  bus4 ();
  logic [13:0] hex8;
  logic [55:0] hex32;
  logic [6:0]  hex4;

  somador_serial_hex #(.WIDTH(8), .NDIG(2)) dut8 (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus8.slave), .hex(hex8));
  somador_serial_hex #(.WIDTH(32), .NDIG(8)) dut32 (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus32.slave), .hex(hex32));
  somador_serial_hex #(.WIDTH(4), .NDIG(1)) dut4 (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus4.slave), .hex(hex4));

  int total = 0;
  int bad   = 0;
  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int lat, nbusy;
    logic [8:0] tot;
    logic [7:0] es;
    logic       ec;
    if (sub) begin
      es = a - b;
      ec = (a >= b);
    end else begin
      tot = a + b + cin;
      es  = tot[7:0];
      ec  = tot[8];
    end
    @(negedge CLOCK_50);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
    @(negedge CLOCK_50);
    bus8.start = 1'b0;
    lat = 1; nbusy = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) nbusy++;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
      @(negedge CLOCK_50);
      lat++;
    end
    check("lat8", 64'(lat), 64'd9);
    check("busy_cycles8", 64'(nbusy), 64'd8);
    check("sum8", 64'(bus8.sum), 64'(es));
    check("cout8", 64'(bus8.cout), 64'(ec));
    check("hex8", 64'(hex8), 64'({seg[es[7:4]], seg[es[3:0]]}));
    check("busy_at_done8", 64'(bus8.busy), 64'd0);
    @(negedge CLOCK_50);
    check("done_width8", 64'(bus8.done), 64'd0);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int lat;
    logic [32:0] tot;
    logic [55:0] eh;
    tot = a + b + cin;
    for (int k = 0; k < 8; k++) eh[7*k +: 7] = seg[tot[4*k +: 4]];
    @(negedge CLOCK_50);
    bus32.start = 1'b1; bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = 1'b0;
    @(negedge CLOCK_50);
    bus32.start = 1'b0;
    lat = 1;
    while (!bus32.done && lat < 80) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check("lat32", 64'(lat), 64'd33);
    check("sum32", 64'(bus32.sum), 64'(tot[31:0]));
    check("cout32", 64'(bus32.cout), 64'(tot[32]));
    check("hex32", 64'(hex32), 64'(eh));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
    int lat;
    logic [3:0] es;
    logic       ec;
    logic [4:0] tot;
    if (sub) begin
      es = a - b;
      ec = (a >= b);
    end else begin
      tot = a + b + cin;
      es  = tot[3:0];
      ec  = tot[4];
    end
    @(negedge CLOCK_50);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub;
    @(negedge CLOCK_50);
    bus4.start = 1'b0;
    lat = 1;
    while (!bus4.done && lat < 20) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check("lat4", 64'(lat), 64'd5);
    check("sum4", 64'(bus4.sum), 64'(es));
    check("cout4", 64'(bus4.cout), 64'(ec));
    check("hex4", 64'(hex4), 64'(seg[es]));
  endtask

  initial begin
    int ndone, first_i, last_i, overlap, wide, spurious;
    logic prev_done;
    reset = 1'b1;
    bus8.start = 0;  bus8.a = 0;  bus8.b = 0;  bus8.cin = 0;  bus8.sub = 0;
    bus32.start = 0; bus32.a = 0; bus32.b = 0; bus32.cin = 0; bus32.sub = 0;
    bus4.start = 0;  bus4.a = 0;  bus4.b = 0;  bus4.cin = 0;  bus4.sub = 0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_sum", 64'(bus8.sum), 64'd0);
    check("rst_cout", 64'(bus8.cout), 64'd0);
    check("rst_hex", 64'(hex8), 64'({seg[0], seg[0]}));

    run8(8'h3C, 8'hA5, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h00, 1'b1, 1'b0);
    run8(8'h10, 8'h01, 1'b0, 1'b1);
    run8(8'h01, 8'h02, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) run8(8'(k), 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // start held for 20 cycles; operands scrambled whenever the op is in flight
    ndone = 0; first_i = -1; last_i = -1; overlap = 0; wide = 0; prev_done = 1'b0;
    @(negedge CLOCK_50);
    for (int i = 0; i < 32; i++) begin
      bus8.start = (i < 20);
      if (bus8.busy) begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
      end else begin
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b0;
      end
      @(negedge CLOCK_50);
      if (bus8.done) begin
        ndone++;
        if (first_i < 0) first_i = i;
        last_i = i;
        check("held_sum", 64'(bus8.sum), 64'h02);
      end
      if (bus8.done && bus8.busy) overlap++;
      if (bus8.done && prev_done) wide++;
      prev_done = bus8.done;
    end
    bus8.start = 1'b0;
    check("held_ops", 64'(ndone), 64'd2);
    check("held_period", 64'(last_i - first_i), 64'd10);
    check("held_overlap", 64'(overlap), 64'd0);
    check("held_wide", 64'(wide), 64'd0);

    // abort mid-shift
    @(negedge CLOCK_50);
    bus8.start = 1'b1; bus8.a = 8'h3C; bus8.b = 8'hA5; bus8.cin = 1'b0; bus8.sub = 1'b0;
    @(negedge CLOCK_50);
    bus8.start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("abort_busy", 64'(bus8.busy), 64'd0);
    check("abort_sum", 64'(bus8.sum), 64'd0);
    check("abort_cout", 64'(bus8.cout), 64'd0);
    check("abort_hex", 64'(hex8), 64'({seg[0], seg[0]}));
    spurious = 0;
    repeat (12) begin
      @(negedge CLOCK_50);
      if (bus8.done || bus8.busy) spurious++;
    end
    check("abort_nodone", 64'(spurious), 64'd0);
    run8(8'h02, 8'h03, 1'b0, 1'b0);

    // reset and start together: start is dropped
    @(negedge CLOCK_50);
    reset = 1'b1; bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22;
    @(negedge CLOCK_50);
    reset = 1'b0; bus8.start = 1'b0;
    check("rststart_busy", 64'(bus8.busy), 64'd0);
    @(negedge CLOCK_50);
    check("rststart_busy2", 64'(bus8.busy), 64'd0);
    check("rststart_sum", 64'(bus8.sum), 64'd0);

    run32(32'hFFFF_FFFF, 32'h1, 1'b0);
    run32($urandom, $urandom, 1'($urandom));
    run4(4'hF, 4'h1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
